frequency_divider: RTL and testbench

Clock-generation block that derives four output clocks from one 50 MHz input clock: 1 MHz, 10 MHz, 20 MHz (average) and a gated 50 MHz copy. It sits at the top of the multiplier design, ahead of any logic that needs slower or gated clocks. All derived clocks share one divide-by-5 / divide-by-10 counter chain, so their edges are phase-aligned.

---
 rtl/freq_div_pkg.sv | 18 +
 rtl/frequency_divider_if.sv | 13 +
 rtl/mod_n_counter.sv | 38 +++
 rtl/frequency_divider.sv | 88 ++++++++
 tb/tb_frequency_divider.sv | 110 +++++++++++
 5 files changed

// File: rtl/freq_div_pkg.sv
// Shared constants for the frequency divider: counter moduli and the count
// values that the registered clock decodes look for.
`timescale 1ns/1ps
package freq_div_pkg;

  localparam int DIV_SLOW_C5  = 5;
  localparam int DIV_SLOW_C10 = 10;

  localparam int P10_HIGH_MAX = 1;
  localparam int A20_PHASE    = 0;
  localparam int B20_SET      = 2;
  localparam int B20_CLR      = 3;
  localparam int C10_HIGH_MAX = 4;

  localparam int C5_W  = $clog2(DIV_SLOW_C5);
  localparam int C10_W = $clog2(DIV_SLOW_C10);

endpackage

// File: rtl/frequency_divider_if.sv
// Bundle of derived clock outputs; the divider drives it and clock consumers read it.
`timescale 1ns/1ps
interface frequency_divider_if;

  logic clk_1MHz;
  logic clk_10MHz;
  logic clk_20MHz;
  logic clk_50MHz;

  modport master (output clk_1MHz, output clk_10MHz, output clk_20MHz, output clk_50MHz);
  modport slave  (input  clk_1MHz, input  clk_10MHz, input  clk_20MHz, input  clk_50MHz);

endinterface

// File: rtl/mod_n_counter.sv
// Modulo-N up counter with async active-low reset to a chosen value; exposes
// the next-state count so callers can register decodes with no extra latency.
`timescale 1ns/1ps
module mod_n_counter
  import freq_div_pkg::*;
#(
  parameter int MODULUS     = 5,
  parameter int RESET_VALUE = MODULUS - 1,
  parameter int WIDTH       = $clog2(MODULUS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             wrap
);

  // wrap is high during the cycle whose closing edge returns the count to zero
  always_comb begin
    wrap       = en && (count == WIDTH'(MODULUS - 1));
    count_next = count;
    if (wrap) begin
      count_next = '0;
    end else if (en) begin
      count_next = count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= WIDTH'(RESET_VALUE);
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/frequency_divider.sv
// Derives phase-aligned 1, 10, 20 (average) and gated 50 MHz clocks from a
// 50 MHz source using one shared divide-by-5 / divide-by-10 counter chain.
`timescale 1ns/1ps
module frequency_divider
  import freq_div_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst,
  frequency_divider_if.master clks
);

  logic [C5_W-1:0]  c5;
  logic [C5_W-1:0]  c5_next;
  logic             c5_wrap;
  logic [C10_W-1:0] c10;
  logic [C10_W-1:0] c10_next;
  logic             c10_wrap;

  logic p10;
  logic n10;
  logic a20;
  logic b20;
  logic s1;

  mod_n_counter #(
    .MODULUS     (DIV_SLOW_C5),
    .RESET_VALUE (DIV_SLOW_C5 - 1),
    .WIDTH       (C5_W)
  ) u_c5 (
    .clk        (clk_in),
    .rst        (rst),
    .en         (1'b1),
    .count      (c5),
    .count_next (c5_next),
    .wrap       (c5_wrap)
  );

  mod_n_counter #(
    .MODULUS     (DIV_SLOW_C10),
    .RESET_VALUE (DIV_SLOW_C10 - 1),
    .WIDTH       (C10_W)
  ) u_c10 (
    .clk        (clk_in),
    .rst        (rst),
    .en         (c5_wrap),
    .count      (c10),
    .count_next (c10_next),
    .wrap       (c10_wrap)
  );

  // Only the next-state slow count feeds the decode; its registered value and wrap are spare.
  logic unused_c10;
  assign unused_c10 = ^{c10, c10_wrap};

  // Decoding the next-state count lets every derived clock rise on the first edge after reset.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      p10 <= 1'b0;
      a20 <= 1'b0;
      s1  <= 1'b0;
    end else begin
      p10 <= (c5_next <= C5_W'(P10_HIGH_MAX));
      a20 <= (c5_next == C5_W'(A20_PHASE));
      s1  <= (c10_next <= C10_W'(C10_HIGH_MAX));
    end
  end

  // Falling-edge flops supply the half-cycle resolution for the 10 and 20 MHz outputs.
  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) begin
      n10 <= 1'b0;
      b20 <= 1'b0;
    end else begin
      n10 <= p10;
      if (c5 == C5_W'(B20_SET)) begin
        b20 <= 1'b1;
      end else if (c5 == C5_W'(B20_CLR)) begin
        b20 <= 1'b0;
      end
    end
  end

  assign clks.clk_1MHz  = s1;
  assign clks.clk_10MHz = p10 | n10;
  assign clks.clk_20MHz = a20 | b20;
  assign clks.clk_50MHz = clk_in & rst;

endmodule

// File: tb/tb_frequency_divider.sv
// Bench for frequency_divider: samples every half-cycle midpoint and compares
// against a time-based model of the expected clock waveforms.
`timescale 1ns/1ps
module tb_frequency_divider;

  logic clk_in;
  logic rst;

  frequency_divider_if clks();

  frequency_divider dut (
    .clk_in (clk_in),
    .rst    (rst),
    .clks   (clks)
  );

  int     passCount  = 0;
  int     checkCount = 0;
  longint t0         = -1;

  initial begin
    clk_in = 1'b0;
    forever #10 clk_in = ~clk_in;
  end

  // Expected {50, 20, 10, 1} MHz levels from elapsed half-cycles since the first active posedge.
  function automatic logic [3:0] modelOutputs(longint t);
    logic [3:0] e;
    longint     h;
    e = 4'b0000;
    if (rst === 1'b1) begin
      e[3] = ((t / 10) % 2) == 1;
      if (t0 >= 0 && t >= t0) begin
        h    = (t - t0) / 10;
        e[0] = (h % 100) < 50;
        e[1] = (h % 10) < 5;
        e[2] = (h % 5) < 2;
      end
    end
    return e;
  endfunction

  function automatic logic [3:0] observedOutputs();
    return {clks.clk_50MHz, clks.clk_20MHz, clks.clk_10MHz, clks.clk_1MHz};
  endfunction

  task automatic checkOutput(string tag, logic [3:0] observed, logic [3:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at %0t ns: observed {50,20,10,1}=%b expected=%b",
               tag, $time, observed, expected);
    end
  endtask

  task automatic sampleNow(string tag);
    checkOutput(tag, observedOutputs(), modelOutputs(longint'($time)));
  endtask

  task automatic nextMid();
    #(15 - ($time % 10));
  endtask

  task automatic applyStimulus(int mids, string tag);
    repeat (mids) begin
      nextMid();
      sampleNow(tag);
    end
  endtask

  // Called from a half-cycle midpoint; assert and release both land between clk_in edges.
  task automatic applyReset(int assertOfs, int holdMids, int releaseOfs);
    #(assertOfs);
    rst = 1'b0;
    #1;
    sampleNow("reset_immediate");
    applyStimulus(holdMids, "reset_hold");
    #(releaseOfs);
    rst = 1'b1;
    t0  = ((longint'($time) - 10) / 20 + 1) * 20 + 10;
  endtask

  initial begin
    rst = 1'b0;
    #5;
    sampleNow("reset_start");
    applyStimulus(4, "reset_start");

    // Release just after the 50 ns edge, so counting begins on the 70 ns posedge.
    #6;
    rst = 1'b1;
    t0  = 70;
    applyStimulus(115, "first_run");
    applyStimulus(13, "first_run");

    applyReset(8, 7, 8);
    applyStimulus(120, "restart");

    for (int i = 0; i < 8; i++) begin
      applyReset(int'($urandom_range(1, 4)), int'($urandom_range(1, 6)),
                 int'($urandom_range(1, 4)));
      applyStimulus(int'($urandom_range(30, 220)), "random_run");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
